// File: rtl/multicycle_control_unit_if.sv
// Handshake and strobe bundle between the multi-cycle control unit and the core datapath.
// The master side is the control unit; the slave side is the datapath and memories.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                imem_ready;
  logic                dmem_ready;
  logic                alu_done;
  logic                imem_rd;
  logic                ir_wr;
  logic                pc_wr;
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_start;
  logic                reg_wr;
  logic                reg_dst;
  logic                alu_src;
  logic                jump;
  logic                jal;
  logic                cmp;
  logic                mov;
  logic                mem_rd;
  logic                mem_wr;
  logic                mem_to_reg;
  logic                instr_done;
  logic [CNT_W-1:0]    instr_count;
  logic                trap;
  logic [2:0]          state;

  modport master (
    input  opcode, imem_ready, dmem_ready, alu_done,
    output imem_rd, ir_wr, pc_wr, alu_op, alu_start, reg_wr, reg_dst, alu_src,
           jump, jal, cmp, mov, mem_rd, mem_wr, mem_to_reg, instr_done,
           instr_count, trap, state
  );

  modport slave (
    output opcode, imem_ready, dmem_ready, alu_done,
    input  imem_rd, ir_wr, pc_wr, alu_op, alu_start, reg_wr, reg_dst, alu_src,
           jump, jal, cmp, mov, mem_rd, mem_wr, mem_to_reg, instr_done,
           instr_count, trap, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 16-bit RISC core: FETCH/DECODE/EXEC/MEM/WB sequencing,
// handshake timeouts into a sticky TRAP state, and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3,
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_unit_if.master bus
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_ADDI = 4'h2, OP_MUL = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4, OP_OR  = 4'h5, OP_DIV  = 4'h6, OP_JAL = 4'h7;
  localparam logic [3:0] OP_CMP = 4'h8, OP_MOV = 4'h9, OP_J    = 4'hA, OP_LI  = 4'hB;
  localparam logic [3:0] OP_LW  = 4'hC, OP_SW  = 4'hD, OP_SLT  = 4'hE, OP_SGT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t              cur_state, next_state;
  logic [OPCODE_W-1:0] ir;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]    count;
  logic [3:0]          op;
  logic                illegal;
  logic                is_muldiv;
  logic                in_wait;
  logic                at_limit;
  logic                retire;
  logic [2:0]          alu_code;

  assign op        = ir[3:0];
  assign illegal   = |(ir >> 4);
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  assign in_wait   = (cur_state == S_FETCH) || (cur_state == S_MEM) ||
                     ((cur_state == S_EXEC) && is_muldiv);
  // Ready is checked before at_limit, so a ready on the final permitted cycle still wins.
  assign at_limit  = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
      ir        <= '0;
      wait_cnt  <= '0;
      count     <= '0;
    end else begin
      cur_state <= next_state;
      if ((cur_state == S_FETCH) && bus.imem_ready)
        ir <= bus.opcode;
      if (in_wait && (next_state == cur_state))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (retire)
        count <= count + 1'b1;
    end
  end

  always_comb begin
    alu_code = 3'b111;
    case (op)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: alu_code = 3'b000;
      OP_MUL:                        alu_code = 3'b001;
      OP_AND:                        alu_code = 3'b010;
      OP_OR:                         alu_code = 3'b011;
      OP_DIV:                        alu_code = 3'b100;
      OP_SLT:                        alu_code = 3'b101;
      OP_SGT:                        alu_code = 3'b110;
      default:                       alu_code = 3'b111;
    endcase
  end

  always_comb begin
    next_state     = cur_state;
    retire         = 1'b0;
    bus.imem_rd    = 1'b0;
    bus.ir_wr      = 1'b0;
    bus.pc_wr      = 1'b0;
    bus.alu_op     = ALU_OP_W'(3'b111);
    bus.alu_start  = 1'b0;
    bus.reg_wr     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.alu_src    = 1'b0;
    bus.jump       = 1'b0;
    bus.jal        = 1'b0;
    bus.cmp        = 1'b0;
    bus.mov        = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_to_reg = 1'b0;
    case (cur_state)
      S_FETCH: begin
        bus.imem_rd = 1'b1;
        if (bus.imem_ready) begin
          bus.ir_wr  = 1'b1;
          bus.pc_wr  = 1'b1;
          next_state = S_DECODE;
        end else if (at_limit) begin
          next_state = S_TRAP;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          next_state = S_TRAP;
        end else if (op == OP_NOP) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        bus.alu_op  = ALU_OP_W'(alu_code);
        bus.alu_src = (op == OP_ADDI) || (op == OP_LI) || (op == OP_LW) || (op == OP_SW);
        bus.cmp     = (op == OP_CMP) || (op == OP_SLT) || (op == OP_SGT);
        bus.mov     = (op == OP_MOV);
        case (op)
          OP_MUL, OP_DIV: begin
            bus.alu_start = (wait_cnt == '0);
            if (bus.alu_done)
              next_state = S_WB;
            else if (at_limit)
              next_state = S_TRAP;
          end
          OP_J: begin
            bus.pc_wr  = 1'b1;
            bus.jump   = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
          end
          OP_JAL: begin
            bus.pc_wr  = 1'b1;
            bus.jal    = 1'b1;
            next_state = S_WB;
          end
          OP_LW, OP_SW: next_state = S_MEM;
          default:      next_state = S_WB;
        endcase
      end
      S_MEM: begin
        bus.mem_rd = (op == OP_LW);
        bus.mem_wr = (op == OP_SW);
        if (bus.dmem_ready) begin
          if (op == OP_SW) begin
            retire     = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end else if (at_limit) begin
          next_state = S_TRAP;
        end
      end
      S_WB: begin
        bus.reg_wr     = 1'b1;
        bus.reg_dst    = (op == OP_ADD) || (op == OP_LI) || (op == OP_LW);
        bus.mem_to_reg = (op == OP_LW);
        retire         = 1'b1;
        next_state     = S_FETCH;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_TRAP;
    endcase
  end

  assign bus.instr_done  = retire;
  assign bus.instr_count = count;
  assign bus.trap        = (cur_state == S_TRAP);
  assign bus.state       = cur_state;
endmodule
